// File: rtl/rsa_pkg.sv
// Shared widths, FSM states and coefficient type for the RSA key-generation datapath.
package rsa_pkg;
    localparam int unsigned PW = 7;
    localparam int unsigned NW = 2 * PW;
    localparam int unsigned TW = NW + 2;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        INIT,
        EUCLID,
        DONE
    } state_e;

    typedef logic signed [TW-1:0] coef_t;
endpackage

// File: rtl/rsa_euclid_step.sv
// One extended-Euclid division step on remainders r0/r1 and Bezout coefficients t0/t1.
module rsa_euclid_step
    import rsa_pkg::*;
(
    input  logic [NW-1:0]        r0_i,
    input  logic [NW-1:0]        r1_i,
    input  logic signed [TW-1:0] t0_i,
    input  logic signed [TW-1:0] t1_i,
    output logic [NW-1:0]        r0_o,
    output logic [NW-1:0]        r1_o,
    output logic signed [TW-1:0] t0_o,
    output logic signed [TW-1:0] t1_o,
    output logic                 zero_o
);
    logic [NW-1:0] quo;
    coef_t         quo_s;

    // Intermediate products are truncated; the true results always fit the register widths.
    always_comb begin
        quo    = '0;
        quo_s  = '0;
        r0_o   = r0_i;
        r1_o   = r1_i;
        t0_o   = t0_i;
        t1_o   = t1_i;
        zero_o = (r1_i == '0);
        if (!zero_o) begin
            quo   = r0_i / r1_i;
            quo_s = TW'({2'b00, quo});
            r0_o  = r1_i;
            r1_o  = r0_i - quo * r1_i;
            t0_o  = t1_i;
            t1_o  = t0_i - quo_s * t1_i;
        end
    end
endmodule

// File: rtl/rsa_keygen.sv
// RSA key generation: n = p*q, phi = (p-1)(q-1), d = e^-1 mod phi via iterative extended Euclid.
module rsa_keygen
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] p,
    input  logic [PW-1:0] q,
    input  logic [NW-1:0] e,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] n,
    output logic [NW-1:0] phi,
    output logic [NW-1:0] d
);
    state_e        state_q;
    logic [PW-1:0] p_q, q_q;
    logic [NW-1:0] e_q;
    logic [NW-1:0] r0_q, r1_q;
    coef_t         t0_q, t1_q;
    logic          busy_q, done_q, err_q;
    logic [NW-1:0] n_q, phi_q, d_q;

    logic [NW-1:0] r0_d, r1_d;
    coef_t         t0_d, t1_d;
    logic          zero;
    coef_t         t0_fix;
    logic          bad_param;

    rsa_euclid_step u_step (
        .r0_i   (r0_q),
        .r1_i   (r1_q),
        .t0_i   (t0_q),
        .t1_i   (t1_q),
        .r0_o   (r0_d),
        .r1_o   (r1_d),
        .t0_o   (t0_d),
        .t1_o   (t1_d),
        .zero_o (zero)
    );

    assign t0_fix    = (t0_q < 0) ? (t0_q + TW'(phi_q)) : t0_q;
    assign bad_param = (p_q < PW'(2)) || (q_q < PW'(2)) || (e_q < NW'(2)) || (e_q >= phi_q);

    // Rejected parameters enter EUCLID with r0=r1=0, so the gcd test flags err one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            e_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= '0;
            phi_q   <= '0;
            d_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        p_q     <= p;
                        q_q     <= q;
                        e_q     <= e;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        d_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    n_q     <= NW'(p_q) * NW'(q_q);
                    phi_q   <= (NW'(p_q) - NW'(1)) * (NW'(q_q) - NW'(1));
                    state_q <= INIT;
                end
                INIT: begin
                    r0_q    <= bad_param ? '0 : phi_q;
                    r1_q    <= bad_param ? '0 : e_q;
                    t0_q    <= '0;
                    t1_q    <= TW'(1);
                    state_q <= EUCLID;
                end
                EUCLID: begin
                    if (!zero) begin
                        r0_q <= r0_d;
                        r1_q <= r1_d;
                        t0_q <= t0_d;
                        t1_q <= t1_d;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        if (r0_q != NW'(1)) begin
                            err_q <= 1'b1;
                            d_q   <= '0;
                        end else begin
                            d_q   <= NW'(t0_fix);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign n    = n_q;
    assign phi  = phi_q;
    assign d    = d_q;
endmodule
